// File: rtl/chdr_pattern_checker_if.sv
// ---------------------------------------------------------------------------
// chdr_pattern_checker_if
// Purpose : AXI-Stream style CHDR bus bundle between a line source and the
//           pattern checker.
// Signals : tdata  [CHDR_W] CHDR line
//           tlast           last line of packet
//           tvalid          line valid
//           tready          sink ready
// Modports: master drives tdata/tlast/tvalid; slave drives tready.
// ---------------------------------------------------------------------------
interface chdr_pattern_checker_if #(
    parameter int CHDR_W = 64
);
    logic [CHDR_W-1:0] tdata;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/chdr_pattern_checker.sv
// ---------------------------------------------------------------------------
// chdr_pattern_checker
// Purpose : Receive-side checker for the null source pattern stream. Each
//           packet is a header line plus N payload lines; payload line i is
//           {~i, i, ~i, i} (16-bit fields), i continuous across packets.
//           Checks seqnum continuity, header length, payload line count and
//           payload pattern; keeps saturating statistics.
// Ports   : rfnoc_chdr_clk     clock
//           rfnoc_chdr_rst_n   synchronous active-low reset
//           s_axis             CHDR input bus (slave modport, never stalls)
//           enable             check enable, sampled on the header beat
//           clear              one-cycle clear of statistics and lock
//           cfg_lines_per_pkt  expected payload lines minus 1
//           line_cnt           payload lines checked
//           pkt_cnt            packets checked
//           err_cnt            packets with at least one error
//           err_flags          sticky {SIZE, DATA, LEN, SEQ}
//           err_pulse          one-cycle strobe per errored packet
// ---------------------------------------------------------------------------
module chdr_pattern_checker #(
    parameter int CHDR_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic                   rfnoc_chdr_clk,
    input  logic                   rfnoc_chdr_rst_n,
    chdr_pattern_checker_if.slave  s_axis,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [15:0]            cfg_lines_per_pkt,
    output logic [CNT_W-1:0]       line_cnt,
    output logic [CNT_W-1:0]       pkt_cnt,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [3:0]             err_flags,
    output logic                   err_pulse
);

    if (CHDR_W != 64) begin : g_bad_width
        $error("chdr_pattern_checker supports only CHDR_W = 64");
    end

    typedef enum logic [1:0] {
        ST_HDR,
        ST_PAYLOAD,
        ST_SKIP
    } state_t;

    localparam int unsigned FLAG_SEQ  = 0;
    localparam int unsigned FLAG_LEN  = 1;
    localparam int unsigned FLAG_DATA = 2;
    localparam int unsigned FLAG_SIZE = 3;

    state_t           r_state;
    logic             r_tready;
    logic             r_locked;
    logic             r_err_pulse;
    logic [15:0]      r_exp_seq;
    logic [15:0]      r_exp_idx;
    logic [15:0]      r_len;
    logic [16:0]      r_beats;
    logic [3:0]       r_marks;
    logic [3:0]       r_err_flags;
    logic [CNT_W-1:0] r_line_cnt;
    logic [CNT_W-1:0] r_pkt_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_beat;
    logic             w_last;
    logic             w_consistent;
    logic             w_close;
    logic [15:0]      w_idx;
    logic [15:0]      w_hdr_seq;
    logic [15:0]      w_hdr_len;
    logic [15:0]      w_len_expect;
    logic [16:0]      w_lines_expect;
    logic [3:0]       w_marks;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign w_beat    = s_axis.tvalid && r_tready;
    assign w_last    = s_axis.tlast;
    assign w_idx     = s_axis.tdata[15:0];
    assign w_hdr_seq = s_axis.tdata[47:32];
    assign w_hdr_len = s_axis.tdata[31:16];

    assign w_consistent = (s_axis.tdata[47:32] == w_idx) &&
                          (s_axis.tdata[31:16] == ~w_idx) &&
                          (s_axis.tdata[63:48] == ~w_idx);

    // r_beats starts at 1 on the header, so on the tlast beat (before its own
    // increment) it equals the number of payload lines in the packet.
    assign w_len_expect   = {r_beats[12:0], 3'b000};
    assign w_lines_expect = {1'b0, cfg_lines_per_pkt} + 17'd1;

    assign w_close = w_beat && !clear && w_last &&
                     ((r_state == ST_HDR && enable) || r_state == ST_PAYLOAD);

    // Per-packet marks including the beat currently on the bus.
    always_comb begin
        w_marks = r_marks;
        if (r_state == ST_HDR) begin
            w_marks = '0;
            if (r_locked && (w_hdr_seq != r_exp_seq)) w_marks[FLAG_SEQ] = 1'b1;
            if (w_last) w_marks[FLAG_SIZE] = 1'b1;
        end else if (r_state == ST_PAYLOAD) begin
            if (!w_consistent) begin
                w_marks[FLAG_DATA] = 1'b1;
            end else if (r_locked && (w_idx != r_exp_idx)) begin
                w_marks[FLAG_DATA] = 1'b1;
            end
            if (w_last) begin
                if (r_beats != w_lines_expect) w_marks[FLAG_SIZE] = 1'b1;
                if (r_len != w_len_expect)     w_marks[FLAG_LEN]  = 1'b1;
            end
        end
    end

    always_ff @(posedge rfnoc_chdr_clk) begin
        if (!rfnoc_chdr_rst_n) begin
            r_state     <= ST_HDR;
            r_tready    <= 1'b0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_exp_seq   <= '0;
            r_exp_idx   <= '0;
            r_len       <= '0;
            r_beats     <= '0;
            r_marks     <= '0;
            r_err_flags <= '0;
            r_line_cnt  <= '0;
            r_pkt_cnt   <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_tready    <= 1'b1;
            r_err_pulse <= 1'b0;
            if (clear) begin
                r_line_cnt  <= '0;
                r_pkt_cnt   <= '0;
                r_err_cnt   <= '0;
                r_err_flags <= '0;
                r_marks     <= '0;
                r_locked    <= 1'b0;
                if ((w_beat && w_last) || (r_state == ST_HDR && !w_beat)) begin
                    r_state <= ST_HDR;
                end else begin
                    r_state <= ST_SKIP;
                end
            end else begin
                if (w_beat) begin
                    case (r_state)
                        ST_HDR: begin
                            if (!enable) begin
                                if (!w_last) r_state <= ST_SKIP;
                            end else begin
                                r_len     <= w_hdr_len;
                                r_beats   <= 17'd1;
                                r_exp_seq <= w_hdr_seq + 16'd1;
                                r_marks   <= w_marks;
                                if (!w_last) r_state <= ST_PAYLOAD;
                            end
                        end
                        ST_PAYLOAD: begin
                            if (r_beats != '1) r_beats <= r_beats + 17'd1;
                            r_marks    <= w_marks;
                            r_exp_idx  <= w_idx + 16'd1;
                            r_line_cnt <= sat_inc(r_line_cnt);
                            if (w_consistent) r_locked <= 1'b1;
                            if (w_last) r_state <= ST_HDR;
                        end
                        ST_SKIP: begin
                            if (w_last) r_state <= ST_HDR;
                        end
                        default: r_state <= ST_HDR;
                    endcase
                end
                if (w_close) begin
                    r_pkt_cnt <= sat_inc(r_pkt_cnt);
                    if (|w_marks) begin
                        r_err_cnt   <= sat_inc(r_err_cnt);
                        r_err_flags <= r_err_flags | w_marks;
                        r_err_pulse <= 1'b1;
                    end
                end
            end
        end
    end

    assign s_axis.tready = r_tready;
    assign line_cnt      = r_line_cnt;
    assign pkt_cnt       = r_pkt_cnt;
    assign err_cnt       = r_err_cnt;
    assign err_flags     = r_err_flags;
    assign err_pulse     = r_err_pulse;

endmodule

// File: tb/tb_chdr_pattern_checker.sv
// ---------------------------------------------------------------------------
// tb_chdr_pattern_checker
// Purpose : Self-checking bench for chdr_pattern_checker. Packets are built as
//           queues of lines, driven with random idle gaps, and a packet-level
//           reference model predicts the statistics. A second instance with
//           4-bit counters observes the same stream to exercise saturation.
// ---------------------------------------------------------------------------
module tb_chdr_pattern_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic [15:0] cfg_lines_per_pkt;

    logic [31:0] line_cnt, pkt_cnt, err_cnt;
    logic [3:0]  err_flags;
    logic        err_pulse;
    logic [3:0]  s_line_cnt, s_pkt_cnt, s_err_cnt;
    logic [3:0]  s_err_flags;
    logic        s_err_pulse;

    chdr_pattern_checker_if #(.CHDR_W(64)) bus ();
    chdr_pattern_checker_if #(.CHDR_W(64)) bus_s ();

    assign bus_s.tdata  = bus.tdata;
    assign bus_s.tlast  = bus.tlast;
    assign bus_s.tvalid = bus.tvalid;

    chdr_pattern_checker #(.CHDR_W(64), .CNT_W(32)) dut (
        .rfnoc_chdr_clk    (clk),
        .rfnoc_chdr_rst_n  (rst_n),
        .s_axis            (bus),
        .enable            (enable),
        .clear             (clear),
        .cfg_lines_per_pkt (cfg_lines_per_pkt),
        .line_cnt          (line_cnt),
        .pkt_cnt           (pkt_cnt),
        .err_cnt           (err_cnt),
        .err_flags         (err_flags),
        .err_pulse         (err_pulse)
    );

    chdr_pattern_checker #(.CHDR_W(64), .CNT_W(4)) dut_small (
        .rfnoc_chdr_clk    (clk),
        .rfnoc_chdr_rst_n  (rst_n),
        .s_axis            (bus_s),
        .enable            (enable),
        .clear             (clear),
        .cfg_lines_per_pkt (cfg_lines_per_pkt),
        .line_cnt          (s_line_cnt),
        .pkt_cnt           (s_pkt_cnt),
        .err_cnt           (s_err_cnt),
        .err_flags         (s_err_flags),
        .err_pulse         (s_err_pulse)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned pulse_seen = 0;

    always @(negedge clk) begin
        if (err_pulse === 1'b1) pulse_seen++;
    end

    // reference model state
    longint      m_line, m_pkt, m_err, m_pulses;
    logic [3:0]  m_flags;
    logic        m_locked;
    logic [15:0] m_exp_seq, m_exp_idx;

    logic [63:0] pkt_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] line_of(input logic [15:0] i);
        return {~i, i, ~i, i};
    endfunction

    function automatic longint sat15(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic build_pkt(input logic [15:0] seq, input logic [15:0] len,
                             input logic [15:0] idx0, input int unsigned nlines);
        pkt_q.delete();
        pkt_q.push_back({16'h0000, seq, len, 16'h0000});
        for (int unsigned k = 0; k < nlines; k++) pkt_q.push_back(line_of(idx0 + 16'(k)));
    endtask

    task automatic corrupt(input int unsigned line, input int unsigned bitpos);
        pkt_q[line] = pkt_q[line] ^ (64'd1 << bitpos);
    endtask

    task automatic send_pkt(input logic en_hdr, input int drop_at, input int clr_at);
        int b;
        b = 0;
        while (b < pkt_q.size()) begin
            @(negedge clk);
            clear = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                bus.tvalid = 1'b0;
            end else begin
                bus.tvalid = 1'b1;
                bus.tdata  = pkt_q[b];
                bus.tlast  = (b == pkt_q.size() - 1);
                if (b == 0) enable = en_hdr;
                else if (b == drop_at) enable = 1'b0;
                clear = (b == clr_at);
                b++;
            end
        end
        @(negedge clk);
        bus.tvalid = 1'b0;
        bus.tlast  = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic model_pkt(input logic en_hdr, input int clr_at);
        logic [3:0]  mk;
        logic [15:0] seq, len, i;
        logic [63:0] d;
        int unsigned n;
        if (clr_at >= 0) begin
            m_line = 0; m_pkt = 0; m_err = 0; m_flags = '0; m_locked = 1'b0;
            return;
        end
        if (!en_hdr) return;
        mk  = '0;
        d   = pkt_q[0];
        seq = d[47:32];
        len = d[31:16];
        if (m_locked && seq != m_exp_seq) mk[0] = 1'b1;
        m_exp_seq = seq + 16'd1;
        n = pkt_q.size() - 1;
        if (n == 0) mk[3] = 1'b1;
        for (int unsigned k = 1; k <= n; k++) begin
            d = pkt_q[k];
            i = d[15:0];
            if (d != line_of(i)) begin
                mk[2] = 1'b1;
            end else begin
                if (m_locked && i != m_exp_idx) mk[2] = 1'b1;
                m_locked = 1'b1;
            end
            m_exp_idx = i + 16'd1;
            m_line++;
        end
        if (n > 0) begin
            if (n != int'(cfg_lines_per_pkt) + 1) mk[3] = 1'b1;
            if (len != 16'(n * 8)) mk[1] = 1'b1;
        end
        m_pkt++;
        if (mk != '0) begin
            m_err++;
            m_flags = m_flags | mk;
            m_pulses++;
        end
    endtask

    task automatic check_all(input string tag);
        repeat (2) @(negedge clk);
        check_val({tag, ".line"},   64'(line_cnt),   64'(m_line));
        check_val({tag, ".pkt"},    64'(pkt_cnt),    64'(m_pkt));
        check_val({tag, ".err"},    64'(err_cnt),    64'(m_err));
        check_val({tag, ".flags"},  64'(err_flags),  64'(m_flags));
        check_val({tag, ".pulses"}, 64'(pulse_seen), 64'(m_pulses));
        check_val({tag, ".s_line"}, 64'(s_line_cnt), 64'(sat15(m_line)));
        check_val({tag, ".s_pkt"},  64'(s_pkt_cnt),  64'(sat15(m_pkt)));
        check_val({tag, ".s_err"},  64'(s_err_cnt),  64'(sat15(m_err)));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bus.tvalid = 1'b0; bus.tlast = 1'b0; bus.tdata = '0;
        clear = 1'b0; enable = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst.tready", 64'(bus.tready), 64'd0);
        check_val("rst.line",   64'(line_cnt),   64'd0);
        check_val("rst.pkt",    64'(pkt_cnt),    64'd0);
        check_val("rst.err",    64'(err_cnt),    64'd0);
        check_val("rst.flags",  64'(err_flags),  64'd0);
        check_val("rst.pulse",  64'(err_pulse),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst.tready_up", 64'(bus.tready), 64'd1);
        m_line = 0; m_pkt = 0; m_err = 0; m_flags = '0;
        m_locked = 1'b0; m_exp_seq = '0; m_exp_idx = '0;
    endtask

    // Send a run of well-formed 101-line packets and model each.
    task automatic clean_run(input logic [15:0] seq0, input logic [15:0] idx0, input int unsigned npkt);
        for (int unsigned p = 0; p < npkt; p++) begin
            build_pkt(seq0 + 16'(p), 16'd808, idx0 + 16'(p * 101), 101);
            send_pkt(1'b1, -1, -1);
            model_pkt(1'b1, -1);
        end
    endtask

    initial begin
        m_pulses = 0;
        cfg_lines_per_pkt = 16'd100;
        do_reset();

        // clean stream
        clean_run(16'd0, 16'd0, 10);
        check_all("clean");
        check_val("clean.line_abs", 64'(line_cnt), 64'd1010);

        // one corrupted payload line, then resync
        do_reset();
        for (int unsigned p = 0; p < 10; p++) begin
            build_pkt(16'(p), 16'd808, 16'(p * 101), 101);
            if (p == 3) corrupt(6, 40);
            send_pkt(1'b1, -1, -1);
            model_pkt(1'b1, -1);
        end
        check_all("data");
        check_val("data.flags_abs", 64'(err_flags), 64'h4);

        // seqnum gap and a wrong header length
        do_reset();
        clean_run(16'd0, 16'd0, 4);
        clean_run(16'd5, 16'd404, 1);
        build_pkt(16'd6, 16'd800, 16'd505, 101);
        send_pkt(1'b1, -1, -1);
        model_pkt(1'b1, -1);
        check_all("seqlen");
        check_val("seqlen.flags_abs", 64'(err_flags), 64'h3);

        // index and seqnum wrap
        do_reset();
        clean_run(16'hFFFE, 16'hFFF0, 3);
        check_all("wrap");

        // short packet and header-only packet
        do_reset();
        clean_run(16'd0, 16'd0, 1);
        build_pkt(16'd1, 16'd400, 16'd101, 50);
        send_pkt(1'b1, -1, -1);
        model_pkt(1'b1, -1);
        build_pkt(16'd2, 16'd0, 16'd151, 0);
        send_pkt(1'b1, -1, -1);
        model_pkt(1'b1, -1);
        check_all("size");
        check_val("size.err_abs", 64'(err_cnt), 64'd2);

        // clear mid-packet, relock on a discontinuous packet
        do_reset();
        clean_run(16'd0, 16'd0, 2);
        build_pkt(16'd2, 16'd808, 16'd202, 101);
        send_pkt(1'b1, -1, 41);
        model_pkt(1'b1, 41);
        check_all("clear");
        build_pkt(16'd7, 16'd808, 16'd500, 101);
        send_pkt(1'b1, -1, -1);
        model_pkt(1'b1, -1);
        check_all("relock");

        // enable low at header: whole packet skipped
        build_pkt(16'd8, 16'd808, 16'd601, 101);
        send_pkt(1'b0, -1, -1);
        model_pkt(1'b0, -1);
        check_all("skip");

        // enable dropped mid-packet: packet still checked (error after drop)
        build_pkt(16'd8, 16'd808, 16'd601, 101);
        corrupt(60, 5);
        send_pkt(1'b1, 20, -1);
        model_pkt(1'b1, -1);
        check_all("endrop");

        // randomized mixed traffic
        do_reset();
        begin
            logic [15:0] seq, idx, s;
            logic [63:0] h;
            int unsigned n;
            logic        en;
            cfg_lines_per_pkt = 16'($urandom_range(2, 30));
            seq = 16'($urandom);
            idx = 16'($urandom);
            for (int unsigned p = 0; p < 40; p++) begin
                n = int'(cfg_lines_per_pkt) + 1;
                if ($urandom_range(0, 99) < 15) n = $urandom_range(0, int'(cfg_lines_per_pkt) + 5);
                s = seq;
                if ($urandom_range(0, 99) < 10) s = seq + 16'($urandom_range(1, 5));
                build_pkt(s, 16'(n * 8), idx, n);
                if (n > 0 && $urandom_range(0, 99) < 10) begin
                    h = pkt_q[0];
                    h[31:16] = h[31:16] ^ 16'($urandom_range(1, 65535));
                    pkt_q[0] = h;
                end
                if (n > 0 && $urandom_range(0, 99) < 10) corrupt($urandom_range(1, n), $urandom_range(0, 63));
                en = ($urandom_range(0, 99) >= 12);
                send_pkt(en, (n > 2 && $urandom_range(0, 3) == 0) ? 2 : -1, -1);
                model_pkt(en, -1);
                check_all("rand");
                seq = s + 16'd1;
                idx = idx + 16'(n);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
